// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared CPU datapath types and constants (ALU / register file) |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } rf_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_clear_seq.sv
// +--------------------------------------------------------------------------+
// | reg_file_clear_seq : walks a pointer over the array, one zero per cycle  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module reg_file_clear_seq
  import cpu_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= CLEARING;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEARING: begin
          // A CLEAR seen here is ignored: the sequence never restarts.
          if (r_ptr == C_LAST) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign clr_en  = (r_state == CLEARING);
  assign clr_idx = r_ptr;

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// +--------------------------------------------------------------------------+
// | reg_file : 2R/1W register file feeding the ALU, with sequential clear    |
// | Optional: REG_FILE_BYPASS_EN enables same-cycle write-to-read forwarding |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module reg_file
  import cpu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR,
  output logic              BUSY
);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_en;

  reg_file_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (CLEAR),
    .busy    (BUSY),
    .clr_en  (w_clr_en),
    .clr_idx (w_clr_idx)
  );

  // CLEAR in IDLE and any cycle of an active clear both drop the write.
  assign w_wr_en = WRITE & ~w_clr_en & ~CLEAR & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clr_en) begin
      r_regs[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[INADDRESS] <= IN;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign OUT1 = (w_wr_en && (OUT1ADDRESS == INADDRESS)) ? IN : r_regs[OUT1ADDRESS];
  assign OUT2 = (w_wr_en && (OUT2ADDRESS == INADDRESS)) ? IN : r_regs[OUT2ADDRESS];
`else
  assign OUT1 = r_regs[OUT1ADDRESS];
  assign OUT2 = r_regs[OUT2ADDRESS];
`endif

endmodule

`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file that sits directly upstream of the ALU.
- Two combinational read ports supply the ALU operand buses (OUT1 → op1, OUT2 → op2).
- One clocked write port takes the ALU result for write-back.
- Includes a clear sequencer that zeroes the array one register per cycle, so software can re-initialise the file without a global reset.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- DEPTH, 8, number of registers; must be a power of 2, ≥2.
- ADDR_W, $clog2(DEPTH) = 3, register address width; derived, not overridden.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN  in  DATA_W  write data (ALU result).
- INADDRESS  in  ADDR_W  write register index.
- WRITE  in  1  write enable.
- OUT1ADDRESS  in  ADDR_W  read port 1 index.
- OUT2ADDRESS  in  ADDR_W  read port 2 index.
- OUT1  out  DATA_W  read port 1 data (ALU op1).
- OUT2  out  DATA_W  read port 2 data (ALU op2).
- CLEAR  in  1  request to start a sequential clear of all registers.
- BUSY  out  1  high while a clear sequence is running.

Behaviour:
- One clock (CLK); RESET is synchronous and active-high. At a rising CLK edge with RESET=1:
  - all registers ← 0, state ← IDLE, clear pointer ← 0, BUSY ← 0.
  - RESET overrides WRITE and CLEAR.
  - After that edge, OUT1 = OUT2 = 0.
- Reads:
  - OUT1/OUT2 are purely combinational: regs[OUT1ADDRESS] and regs[OUT2ADDRESS].
  - Both ports may address the same register.
  - Reads are valid in every state, including during a clear, when they return the partially cleared contents.
- Write:
  - Condition at a rising edge: WRITE=1, state=IDLE, CLEAR=0, RESET=0.
  - Effect: regs[INADDRESS] ← IN. The new value appears on a read port after that edge (1-cycle write-to-read latency).
  - WRITE=0 leaves all registers unchanged.
- FSM with two states, IDLE and CLEARING:
  - IDLE with CLEAR=1 at an edge → CLEARING, pointer ← 0, BUSY ← 1.
  - CLEARING, each edge: regs[pointer] ← 0, pointer ← pointer+1.
  - On the edge that clears index DEPTH-1: state ← IDLE, BUSY ← 0, pointer ← 0.
  - BUSY is registered; it is high for exactly DEPTH cycles per clear.
- Boundary conditions:
  - WRITE and CLEAR both high in IDLE: CLEAR wins, the write is dropped.
  - WRITE while BUSY=1: dropped, no register change. The upstream controller must hold off.
  - CLEAR while CLEARING: ignored; the sequence neither restarts nor extends.
  - RESET mid-clear: the whole array is zeroed immediately, state returns to IDLE, BUSY=0.
  - Pointer wraps modulo DEPTH; no out-of-range index is possible.
- No arithmetic beyond the ADDR_W-bit pointer increment.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - When a write is accepted this cycle (WRITE=1, IDLE, CLEAR=0, RESET=0) and OUTnADDRESS == INADDRESS, OUTn = IN combinationally in the same cycle.
  - Register update timing is unchanged.
- Undefined: OUTn always returns the stored value, so the new data is visible only after the edge.

Decomposition:
- Shared package cpu_pkg:
  - constants DATA_W=8, NUM_REGS=8, REG_ADDR_W=3.
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
  - typedef word_t (logic [DATA_W-1:0]).
  - enum rf_state_t {IDLE, CLEARING}.
  - The ALU reuses word_t.
- One natural sub-module: reg_file_clear_seq. It holds the FSM, the pointer and BUSY, and outputs a clear-enable plus a clear-index to the array.

Test Plan:
- Reset: write 0xAA to every register, pulse RESET for 1 cycle → all 8 addresses read 0x00, BUSY=0.
- Write/read: write IN=8 to r1 and IN=15 to r2 → next cycle, OUT1ADDRESS=1, OUT2ADDRESS=2 gives OUT1=8, OUT2=15. Without bypass, OUT1 at r1 shows the old value during the write cycle.
- Clear sequence: load r0..r7 = 1..8, pulse CLEAR → BUSY high for exactly 8 cycles. Mid-clear (cycle 4) r0..r3 read 0 and r4..r7 read 5..8; all 0 when BUSY falls.
- Conflicts: WRITE r3=0x55 together with CLEAR → r3 ends at 0. WRITE r5=0x77 during BUSY → r5 reads 0 after the clear. Second CLEAR while busy → BUSY still 8 cycles.
- Reset mid-clear: assert RESET at clear cycle 3 → next cycle all registers 0, BUSY=0, and a new CLEAR is accepted.
- Bypass (REG_FILE_BYPASS_EN defined): WRITE r4=0x3C with OUT1ADDRESS=4 → OUT1=0x3C in the same cycle. With CLEAR also high, no forwarding occurs.
